muldiv_ctrl: RTL and testbench

RV32M execute-stage controller sitting between the ID/EX pipeline register and the iterative divider.
- Decodes funct3 of M-extension ops.
- Computes multiplies itself in one registered cycle.
- Sequences the divider over its divsel/ready/res handshake.
- Stalls the pipeline while an op is in flight and presents a one-cycle writeback pulse to EX/MEM.

---
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// RV32M execute-stage controller: one-cycle registered multiply, sequenced iterative divide.
// Optional macro DIV_FASTPATH_EN resolves divide-by-zero and signed overflow without the divider.
module muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid_in,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [RD_W-1:0] i_rd_in,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_wb_valid,
    output logic [RD_W-1:0] o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic [2:0]      o_div_sel,
    output logic [XLEN-1:0] o_div_a,
    output logic [XLEN-1:0] o_div_b,
    input  logic            i_div_ready,
    input  logic [XLEN-1:0] i_div_res
);

    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_RUN,
        S_WB,
        S_DRAIN
    } state_t;

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_a, r_b;
    logic [2:0]        r_f3;
    logic [RD_W-1:0]   r_rd;
    logic              r_use_div;

    logic              w_accept, w_is_div, w_fast;
    logic [2:0]        w_sel_code;
    logic              w_sa, w_sb;
    logic signed [XLEN:0]     w_a_ext, w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_is_div   = i_funct3[2];
    assign w_accept   = (r_state == S_IDLE) && i_valid_in && !i_flush;
    assign w_sel_code = {1'b0, i_funct3[1:0]} + 3'd1;

`ifdef DIV_FASTPATH_EN
    assign w_fast = i_funct3[2] && ((i_rs2_val == '0) ||
                    (!i_funct3[0] && i_rs1_val == INT_MIN && i_rs2_val == ONES));
`else
    assign w_fast = 1'b0;
`endif

    // MULH sign-extends both, MULHSU only a; MUL/MULHU are unsigned
    assign w_sa    = (r_f3 == 3'b001) || (r_f3 == 3'b010);
    assign w_sb    = (r_f3 == 3'b001);
    assign w_a_ext = {w_sa & r_a[XLEN-1], r_a};
    assign w_b_ext = {w_sb & r_b[XLEN-1], r_b};
    // the top two bits of the 66-bit product never reach a result, so keep the low 64
    assign w_prod  = 64'(w_a_ext) * 64'(w_b_ext);

    always_comb begin
        w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef DIV_FASTPATH_EN
        // divides parked in the MUL state are only the fast-path special cases
        if (r_f3[2]) begin
            if (r_b == '0)
                w_mul_res = r_f3[1] ? r_a : ONES;
            else
                w_mul_res = r_f3[1] ? '0 : INT_MIN;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = (w_is_div && !w_fast) ? S_DIV_RUN : S_MUL;
            S_MUL:     w_next = i_flush ? S_DRAIN : S_WB;
            S_DIV_RUN: begin
                if (i_flush)          w_next = S_DRAIN;
                else if (i_div_ready) w_next = S_WB;
            end
            S_WB:      w_next = r_use_div ? S_DRAIN : S_IDLE;
            S_DRAIN:   if (!i_div_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE:    o_stall = i_valid_in && !i_flush;
                S_MUL:     o_stall = 1'b1;
                S_DIV_RUN: o_stall = 1'b1;
                S_DRAIN:   o_stall = i_valid_in;
                default:   o_stall = 1'b0;
            endcase
        end
    end

    assign o_wb_valid = (r_state == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_f3      <= '0;
            r_rd      <= '0;
            r_use_div <= 1'b0;
            o_wb_rd   <= '0;
            o_wb_data <= '0;
            o_div_sel <= '0;
            o_div_a   <= '0;
            o_div_b   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a       <= i_rs1_val;
                        r_b       <= i_rs2_val;
                        r_f3      <= i_funct3;
                        r_rd      <= i_rd_in;
                        r_use_div <= w_is_div && !w_fast;
                        if (w_is_div && !w_fast) begin
                            o_div_sel <= w_sel_code;
                            o_div_a   <= i_rs1_val;
                            o_div_b   <= i_rs2_val;
                        end
                    end
                end
                S_MUL: begin
                    if (!i_flush) begin
                        o_wb_data <= w_mul_res;
                        o_wb_rd   <= r_rd;
                    end
                end
                S_DIV_RUN: begin
                    // dropping div_sel is what tells the divider to self-clear
                    if (i_flush) begin
                        o_div_sel <= '0;
                    end else if (i_div_ready) begin
                        o_wb_data <= i_div_res;
                        o_wb_rd   <= r_rd;
                        o_div_sel <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised bench for muldiv_ctrl with a behavioural 32-iteration divider and arithmetic reference.
module tb_muldiv_ctrl;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic valid_in, flush;
    logic [2:0] funct3;
    logic [31:0] rs1, rs2;
    logic [4:0] rd_in;
    logic stall, wb_valid;
    logic [4:0] wb_rd;
    logic [31:0] wb_data, div_a, div_b, div_res;
    logic [2:0] div_sel;
    logic div_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int viol    = 0;
    int wb_seen = 0;
    logic last_div = 1'b0;
    logic [2:0] prev_sel = '0;
    logic [31:0] prev_a = '0, prev_b = '0;
    logic prev_ready = 1'b0, prev_wb = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .i_valid_in(valid_in), .i_funct3(funct3),
        .i_rs1_val(rs1), .i_rs2_val(rs2), .i_rd_in(rd_in), .i_flush(flush),
        .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_div_sel(div_sel), .o_div_a(div_a), .o_div_b(div_b),
        .i_div_ready(div_ready), .i_div_res(div_res)
    );

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] up;
        longint sp;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        up  = {32'b0, a} * {32'b0, b};
        case (f3)
            3'd0: return up[31:0];
            3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); up = sp; return up[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return 1'b0;
`endif
    endfunction

    // divider: 33 busy cycles after it first sees div_sel, ready for 2, clears if div_sel drops early
    always @(posedge clk or posedge rst) begin
        if (rst)               dv_cnt <= 0;
        else if (dv_cnt >= 33) dv_cnt <= (dv_cnt == 34) ? 0 : dv_cnt + 1;
        else if (div_sel != 0) dv_cnt <= dv_cnt + 1;
        else                   dv_cnt <= 0;
    end
    assign div_ready = (dv_cnt == 33) || (dv_cnt == 34);

    always_comb begin
        div_res = 32'hDEAD_BEEF;
        if (div_ready) begin
            case (div_sel)
                3'd1: div_res = ref_op(3'd4, div_a, div_b);
                3'd2: div_res = ref_op(3'd5, div_a, div_b);
                3'd3: div_res = ref_op(3'd6, div_a, div_b);
                3'd4: div_res = ref_op(3'd7, div_a, div_b);
                default: div_res = 32'hDEAD_BEEF;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_sel == 0 && div_sel != 0 && (div_ready || prev_ready)) viol++;
            if (prev_sel != 0 && div_sel != 0 && {prev_sel, prev_a, prev_b} != {div_sel, div_a, div_b}) viol++;
            if (prev_wb && wb_valid) viol++;
        end
        if (wb_valid) wb_seen++;
        prev_sel   = div_sel;
        prev_a     = div_a;
        prev_b     = div_b;
        prev_ready = div_ready;
        prev_wb    = wb_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // present an op at the next cycle; extra = cycles spent in DRAIN before acceptance
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int extra);
        logic fast, via_div;
        logic [2:0] exp_sel;
        int exp_lat, n;
        fast    = is_fast(f3, a, b);
        via_div = f3[2] && !fast;
        exp_lat = (via_div ? 35 : 2) + extra;
        case (f3)
            3'd4: exp_sel = 3'd1;
            3'd5: exp_sel = 3'd2;
            3'd6: exp_sel = 3'd3;
            3'd7: exp_sel = 3'd4;
            default: exp_sel = 3'd0;
        endcase
        if (!via_div) exp_sel = 3'd0;
        @(posedge clk); #1;
        valid_in = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 0) check("stall_c0", 32'(stall), 32'd1);
            if (n == extra + 1) check("div_sel", 32'(div_sel), 32'(exp_sel));
            if (wb_valid) break;
        end
        check("latency", n, exp_lat);
        check("wb_data", wb_data, ref_op(f3, a, b));
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("stall_wb", 32'(stall), 32'd0);
        last_div = via_div;
    endtask

    task automatic gap(input int k);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (k) @(posedge clk);
        last_div = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] specials [4];
        logic [31:0] a, b;
        logic [2:0] f3;
        int w0;
        specials[0] = 32'h0; specials[1] = 32'h1;
        specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
        rst = 1'b1; valid_in = 1'b1; flush = 1'b0; funct3 = 3'd4;
        rs1 = 32'h5; rs2 = 32'h3; rd_in = 5'd1;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_div_sel", 32'(div_sel), 0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0); gap(2);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0); gap(2);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, last_div ? 1 : 0); gap(3);
        do_op(3'd5, 32'h1234, 32'd0, 5'd7, 0); gap(3);
        do_op(3'd7, 32'h1234, 32'd0, 5'd8, 0); gap(3);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0); gap(3);

        // flush in IDLE blocks acceptance
        @(posedge clk); #1;
        valid_in = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; rd_in = 5'd11;
        @(negedge clk);
        check("flush_idle_stall", 32'(stall), 0);
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;

        // flush at cycle 10 of a DIV
        @(posedge clk); #1;
        valid_in = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd12;
        repeat (10) @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b1;
        w0 = wb_seen;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        check("flush_no_wb", wb_seen - w0, 0);
        do_op(3'd5, 32'd100, 32'd7, 5'd13, 0); gap(3);

        // async reset at cycle 20 of a REM
        @(posedge clk); #1;
        valid_in = 1'b1; funct3 = 3'd6; rs1 = 32'd12345; rs2 = 32'd100; rd_in = 5'd14;
        repeat (20) @(posedge clk); #1;
        rst = 1'b1; valid_in = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall), 0);
        check("rst_mid_div_sel", 32'(div_sel), 0);
        check("rst_mid_div_a", div_a, 0);
        check("rst_mid_div_b", div_b, 0);
        check("rst_mid_wb_data", wb_data, 0);
        check("rst_mid_wb_rd", 32'(wb_rd), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_div_idle", 32'(div_ready), 0);
        do_op(3'd0, 32'd6, 32'd9, 5'd15, 0); gap(2);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_op(f3, a, b, 5'($urandom), last_div ? 1 : 0);
            end else begin
                gap(3);
                do_op(f3, a, b, 5'($urandom), 0);
            end
        end
        gap(3);
        check("handshake_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
